// File: rtl/psa_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psa_ctrl_pkg
// Purpose  : Shared constants, types and helpers for the PSA share controller.
//            - Lane geometry (4 lanes x 4 bits).
//            - Saturation constants.
//            - Requester IDs.
//            - Response-buffer state encoding.
//            - Lane overflow helper.
// Revision : 1.0 - initial release
// ============================================================================
package psa_ctrl_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int DATA_W = LANES * LANE_W;

  localparam logic [LANE_W-1:0] LANE_POS_MAX = 4'h7;
  localparam logic [LANE_W-1:0] LANE_NEG_MIN = 4'h8;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  // The response buffer has only two states, so EMPTY/FULL is exactly rsp_valid.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_t;

  // Signed overflow: both operands have the same sign and the sum's sign differs.
  function automatic logic lane_ovf(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/PSA_16bit.sv
`default_nettype none
// ============================================================================
// Module   : PSA_16bit
// Purpose  : 16-bit parallel sub-word adder.
//            - Four independent 4-bit signed lanes with wrap-around sums.
//            - Error is the OR of the per-lane signed overflow flags.
// Ports    : A, B  - 16-bit operands
//            Sum   - per-lane wrapped sum
//            Error - set when any lane overflowed
// Revision : 1.0 - initial release
// ============================================================================
module PSA_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum,
  output logic        Error
);

  logic [3:0] w_lane_err;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [3:0] w_s;
      assign w_s = A[gi*4 +: 4] + B[gi*4 +: 4];
      assign Sum[gi*4 +: 4] = w_s;
      assign w_lane_err[gi] = (A[gi*4+3] == B[gi*4+3]) && (w_s[3] != A[gi*4+3]);
    end
  endgenerate

  assign Error = |w_lane_err;

endmodule
`default_nettype wire

// File: rtl/psa_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : psa_rr_arb2
// Purpose  : Two-way round-robin arbiter.
//            - A lone valid requester is granted.
//            - On a tie, the requester other than the last-granted one wins.
//            - No grant is issued while i_en is low.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            i_valid[1:0] - request valids
//            i_en       - downstream can accept this cycle
//            o_grant[1:0] - one-hot (or zero) grant
// Revision : 1.0 - initial release
// ============================================================================
module psa_rr_arb2
  import psa_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  // Last-granted requester; resetting to REQ_ID_1 lets req0 win the first tie.
  logic       r_last;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = 2'b00;
    if (i_en) begin
      case (i_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = (r_last == REQ_ID_1) ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= REQ_ID_1;
    end else if (|w_grant) begin
      r_last <= w_grant[1] ? REQ_ID_1 : REQ_ID_0;
    end
  end

  assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/psa_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psa_share_ctrl
// Purpose  : Time-shares one PSA_16bit between two requesters.
//            - Round-robin arbitration between the requesters.
//            - One-entry registered response buffer with valid/ready.
//            - Saturating counter of overflowing operations.
// Config   : `define PSA_SAT_EN clamps overflowing lanes in rsp_sum to
//            0x7 (non-negative operands) or 0x8 (negative operands).
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            reqN_valid/a/b, reqN_ready  - requester N operand handshake
//            rsp_valid/rsp_ready         - response handshake
//            rsp_id                      - owning requester of the result
//            rsp_sum, rsp_ovf, rsp_err   - lane sums, lane overflow, OR of ovf
//            err_cnt                     - saturating count of overflowing ops
// Revision : 1.0 - initial release
// ============================================================================
module psa_share_ctrl
  import psa_ctrl_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [15:0]          req0_a,
  input  logic [15:0]          req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [15:0]          req1_a,
  input  logic [15:0]          req1_b,
  output logic                 req1_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [15:0]          rsp_sum,
  output logic [3:0]           rsp_ovf,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] c_ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  rsp_state_t          r_state;
  rsp_state_t          w_state_nxt;

  logic                w_can_accept;
  logic [1:0]          w_grant;
  logic                w_take;
  logic                w_sel;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_psa_sum;
  logic                w_psa_err;
  logic [LANES-1:0]    w_ovf;
  logic [DATA_W-1:0]   w_sum_d;

  logic                r_id;
  logic [DATA_W-1:0]   r_sum;
  logic [LANES-1:0]    r_ovf;
  logic                r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // A full buffer being drained this cycle can be refilled in the same cycle.
  assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;

  psa_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_valid ({req1_valid, req0_valid}),
    .i_en    (w_can_accept),
    .o_grant (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_take     = |w_grant;
  assign w_sel      = w_grant[1];

  assign w_a = w_sel ? req1_a : req0_a;
  assign w_b = w_sel ? req1_b : req0_b;

  PSA_16bit u_psa (
    .A     (w_a),
    .B     (w_b),
    .Sum   (w_psa_sum),
    .Error (w_psa_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_ovf[gi] = lane_ovf(w_a[gi*LANE_W + LANE_W-1],
                                  w_b[gi*LANE_W + LANE_W-1],
                                  w_psa_sum[gi*LANE_W + LANE_W-1]);
`ifdef PSA_SAT_EN
      // On overflow both operands share a sign, so A's MSB picks the clamp.
      assign w_sum_d[gi*LANE_W +: LANE_W] =
          !w_ovf[gi]                    ? w_psa_sum[gi*LANE_W +: LANE_W] :
          w_a[gi*LANE_W + LANE_W-1]     ? LANE_NEG_MIN : LANE_POS_MAX;
`else
      assign w_sum_d[gi*LANE_W +: LANE_W] = w_psa_sum[gi*LANE_W +: LANE_W];
`endif
    end
  endgenerate

  // Response buffer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_take) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_take) begin
          w_state_nxt = ST_FULL;
        end else if (rsp_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Result payload only changes on a transfer, so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id  <= REQ_ID_0;
      r_sum <= '0;
      r_ovf <= '0;
      r_err <= 1'b0;
    end else if (w_take) begin
      r_id  <= w_sel ? REQ_ID_1 : REQ_ID_0;
      r_sum <= w_sum_d;
      r_ovf <= w_ovf;
      r_err <= w_psa_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_take && w_psa_err && (r_err_cnt != c_ERR_MAX)) begin
      r_err_cnt <= r_err_cnt + c_ERR_ONE;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_ovf   = r_ovf;
  assign rsp_err   = r_err;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_psa_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_psa_share_ctrl
// Purpose  : Self-checking bench for psa_share_ctrl (ERR_CNT_W = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_psa_share_ctrl;

  localparam int ERR_CNT_W = 2;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  typedef struct packed {
    logic        id;
    logic [15:0] sum;
    logic [3:0]  ovf;
    logic        err;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req0_valid, req1_valid;
  logic [15:0]          req0_a, req0_b, req1_a, req1_b;
  logic                 req0_ready, req1_ready;
  logic                 rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0]          rsp_sum;
  logic [3:0]           rsp_ovf;
  logic [ERR_CNT_W-1:0] err_cnt;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_exp[$];

  logic m_valid = 1'b0;
  logic m_ptr   = 1'b1;
  int   m_cnt   = 0;
  exp_t m_cur   = '0;

  always #5 clk = ~clk;

  psa_share_ctrl #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.id = id;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] al, bl, s;
      logic       o;
      al = a[i*4 +: 4];
      bl = b[i*4 +: 4];
      s  = al + bl;
      o  = (al[3] == bl[3]) && (s[3] != al[3]);
`ifdef PSA_SAT_EN
      if (o) s = al[3] ? 4'h8 : 4'h7;
`endif
      e.sum[i*4 +: 4] = s;
      e.ovf[i]        = o;
    end
    e.err = |e.ovf;
    return e;
  endfunction

  // One clock cycle: drive, check handshake/hold, clock, pop and check result.
  task automatic step(input logic r, input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                      input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                      input logic rr);
    logic [1:0] g;
    exp_t       e;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1; rsp_ready = rr;
    #1;
    g = 2'b00;
    if (!m_valid || rr) begin
      if (v0 && v1)  g = m_ptr ? 2'b01 : 2'b10;
      else if (v0)   g = 2'b01;
      else if (v1)   g = 2'b10;
    end
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g[0]});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g[1]});
    chk("rsp_valid_pre", {31'd0, rsp_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("hold_sum", {16'd0, rsp_sum}, {16'd0, m_cur.sum});
      chk("hold_id",  {31'd0, rsp_id},  {31'd0, m_cur.id});
      chk("hold_ovf", {28'd0, rsp_ovf}, {28'd0, m_cur.ovf});
    end
    if (!r && g != 2'b00) q_exp.push_back(model(g[1], g[1] ? a1 : a0, g[1] ? b1 : b0));
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_ptr = 1'b1; m_cnt = 0; q_exp.delete();
    end else if (g != 2'b00) begin
      m_valid = 1'b1; m_ptr = g[1];
    end else if (rr) begin
      m_valid = 1'b0;
    end
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    if (!r && g != 2'b00) begin
      if (q_exp.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = q_exp.pop_front();
        m_cur = e;
        chk("rsp_id",  {31'd0, rsp_id},  {31'd0, e.id});
        chk("rsp_sum", {16'd0, rsp_sum}, {16'd0, e.sum});
        chk("rsp_ovf", {28'd0, rsp_ovf}, {28'd0, e.ovf});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        if (e.err && m_cnt < CNT_MAX) m_cnt++;
      end
    end
    if (r) begin
      chk("rst_id",  {31'd0, rsp_id},  32'd0);
      chk("rst_sum", {16'd0, rsp_sum}, 32'd0);
      chk("rst_ovf", {28'd0, rsp_ovf}, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
    end
    chk("err_cnt", {{(32-ERR_CNT_W){1'b0}}, err_cnt}, m_cnt);
  endtask

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Directed vectors with literal expectations.
    step(0, 1, 16'h1234, 16'h1111, 0, 0, 0, 1);
    chk("tp1_sum", {16'd0, rsp_sum}, 32'h2345);
    chk("tp1_ovf", {28'd0, rsp_ovf}, 32'h0);
    chk("tp1_cnt", {30'd0, err_cnt}, 32'd0);

    step(0, 0, 0, 0, 1, 16'h7777, 16'h1111, 1);
`ifdef PSA_SAT_EN
    chk("tp2_sum", {16'd0, rsp_sum}, 32'h7777);
`else
    chk("tp2_sum", {16'd0, rsp_sum}, 32'h8888);
`endif
    chk("tp2_ovf", {28'd0, rsp_ovf}, 32'hF);
    chk("tp2_id",  {31'd0, rsp_id},  32'd1);
    chk("tp2_cnt", {30'd0, err_cnt}, 32'd1);

    step(0, 1, 16'h8888, 16'h8888, 0, 0, 0, 1);
`ifdef PSA_SAT_EN
    chk("tp3_sum", {16'd0, rsp_sum}, 32'h8888);
`else
    chk("tp3_sum", {16'd0, rsp_sum}, 32'h0000);
`endif
    chk("tp3_ovf", {28'd0, rsp_ovf}, 32'hF);

    // Drain, then dropped valids with nothing accepted.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Round-robin alternation from reset.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h0101 * i[15:0], 16'h1010, 1, 16'h2222, 16'h0303 * i[15:0], 1);
      chk("rr_seq", {31'd0, rsp_id}, i % 2);
    end

    // Backpressure hold for three cycles, then drain+refill.
    for (int i = 0; i < 3; i++) step(0, 1, 16'h4321, 16'h1234, 1, 16'h5A5A, 16'hA5A5, 0);
    step(0, 1, 16'h4321, 16'h1234, 1, 16'h5A5A, 16'hA5A5, 1);
    chk("refill_valid", {31'd0, rsp_valid}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Counter saturation.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, i[0] == 1'b0, 16'h7777, 16'h1111, i[0] == 1'b1, 16'h8888, 16'h8888, 1);
      chk("sat_cnt", {30'd0, err_cnt}, (i < 3) ? i + 1 : 3);
    end

    // Reset with a result pending, then the next tie goes to req0.
    chk("pend_valid", {31'd0, rsp_valid}, 32'd1);
    step(1, 1, 16'h1111, 16'h1111, 1, 16'h2222, 16'h2222, 0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_cnt",   {30'd0, err_cnt},   32'd0);
    step(0, 1, 16'h0F0F, 16'h0101, 1, 16'h3333, 16'h4444, 1);
    chk("tie_after_rst", {31'd0, rsp_id}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
